fadd_wb_collector: RTL and testbench
====================================

Name: fadd_wb_collector

Overview:
- Result-side responder for the pipelined FP adder.
- Accepts results, sideband and fflags over a valid/ready handshake and buffers them in a small FIFO.
- Drains the FIFO to the vector register-file write port over a second valid/ready handshake.
- Keeps a per-warp sticky fflags (fcsr accrued-exception) register file that the CSR unit can read and clear.

Parameters:
- EXPWIDTH, 5, exponent width; data width DW = EXPWIDTH+PRECISION+1.
- PRECISION, 3, stored mantissa width.
- DEPTH_WARP, 4, warp-id width; number of warps NW = 2**DEPTH_WARP.
- FIFO_DEPTH, 4, result buffer entries; must be a power of 2 and ≥2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- res_valid_i  in  1  adder result valid
- res_ready_o  out  1  collector can accept a result
- res_data_i  in  DW  FP result
- res_fflags_i  in  5  {NV,DZ,OF,UF,NX}
- res_reg_idxw_i  in  8  destination register index
- res_warpid_i  in  DEPTH_WARP  owning warp
- wb_valid_o  out  1  write-back request
- wb_ready_i  in  1  register file accepts the write
- wb_data_o  out  DW  write data
- wb_reg_idxw_o  out  8  write register index
- wb_warpid_o  out  DEPTH_WARP  write warp
- fflags_rd_warpid_i  in  DEPTH_WARP  CSR read select
- fflags_rd_o  out  5  accrued flags of the selected warp (combinational read)
- fflags_clr_i  in  1  clear request
- fflags_clr_warpid_i  in  DEPTH_WARP  warp to clear
- count_o  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. On reset, FIFO pointers and count go to 0, all NW fflags registers go to 0, wb_valid_o=0, res_ready_o=1, count_o=0. Storage data need not be reset. Reset mid-operation discards buffered entries without emitting them.
- Push: occurs when res_valid_i && res_ready_o; {data, reg_idxw, warpid} is written at wr_ptr, and wr_ptr increments modulo FIFO_DEPTH.
- res_ready_o = (count != FIFO_DEPTH), decoded from the count register only, with no combinational path from wb_ready_i.
- Pop: occurs when wb_valid_o && wb_ready_i; rd_ptr increments modulo FIFO_DEPTH.
- wb_valid_o = (count != 0). wb_data_o, wb_reg_idxw_o and wb_warpid_o present the head entry and stay stable while wb_valid_o=1 && !wb_ready_i.
- Latency: a result pushed at edge N appears on wb_* in the cycle after edge N; minimum latency is 1 cycle.
- Count update: push only +1; pop only −1; simultaneous push and pop leave count unchanged. A simultaneous push/pop when count=FIFO_DEPTH−1 or count=1 must not corrupt data.
- Full: res_ready_o=0, and a pop in that cycle does not allow a push in the same cycle (no ready bypass). Ready rises in the cycle after the pop.
- Empty: wb_valid_o=0, and wb_ready_i is ignored.
- Ordering: strict FIFO, with no reordering across warps.
- fflags accrual: on push, flags[res_warpid_i] |= res_fflags_i. Accrual happens at accept time, not at write-back.
- fflags clear: fflags_clr_i sets flags[fflags_clr_warpid_i] to 0 at the next edge.
- Clear and push to the same warp in the same cycle: the result is res_fflags_i (clear first, then OR).
- Clear and push to different warps in the same cycle: both take effect.
- fflags_rd_o returns the registered value and does not reflect a same-cycle push.

Optional Feature:
- Macro: FADD_WB_BYPASS_EN.
- With the macro defined: when count==0 and res_valid_i=1, the incoming result drives wb_* combinationally in the same cycle with wb_valid_o=1.
  - If wb_ready_i=1 in that cycle, the entry is consumed and not written to the FIFO; count stays 0.
  - If wb_ready_i=0, it is pushed normally.
  - fflags accrue in both cases.
- Without the macro: behaviour is exactly as in Behaviour, with a 1-cycle minimum latency.

Test Plan:
- Reset, then a single push of res_data_i=9'h078 (1.0), idxw=8'h05, warp=2, with wb_ready_i=1 → next cycle wb_valid_o=1, wb_data_o=9'h078, wb_reg_idxw_o=8'h05, wb_warpid_o=2; one cycle later count_o=0, wb_valid_o=0.
- Hold wb_ready_i=0 and push 5 results 9'h001..9'h005 back-to-back → res_ready_o falls after the 4th accept, the 5th is held off and count_o=4. Release wb_ready_i=1 → outputs 001,002,003,004 in order, then 005 is accepted and emitted; no loss or duplication.
- At count=2, assert push and pop in the same cycle for 20 cycles with incrementing data → count_o stays 2 and the output sequence matches the input sequence delayed by 2 entries.
- Push warp 3 with fflags 5'b00001, then warp 3 with 5'b00100, then warp 1 with 5'b10000 → fflags_rd(3)=5'b00101 and fflags_rd(1)=5'b10000. Clear warp 3 in the same cycle as a push to warp 3 with 5'b00010 → fflags_rd(3)=5'b00010.
- Assert rst_n=0 asynchronously mid-clock with count=3 → wb_valid_o=0, count_o=0 and fflags all 0 immediately; no stale entry appears after reset release.
- With FADD_WB_BYPASS_EN defined, empty FIFO, and res_valid_i=1, wb_ready_i=1 with data 9'h0FF → wb_valid_o=1 and wb_data_o=9'h0FF in the same cycle, and count_o remains 0.

Source files
------------

// File: rtl/fadd_wb_collector.sv
// Result collector for the pipelined FP adder: buffers results in a FIFO, drains them to the
// register-file write port, and keeps per-warp sticky fflags. Optional same-cycle bypass: FADD_WB_BYPASS_EN.
module fadd_wb_collector #(
  parameter int EXPWIDTH   = 5,
  parameter int PRECISION  = 3,
  parameter int DEPTH_WARP = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            res_valid_i,
  output logic                            res_ready_o,
  input  logic [EXPWIDTH+PRECISION:0]     res_data_i,
  input  logic [4:0]                      res_fflags_i,
  input  logic [7:0]                      res_reg_idxw_i,
  input  logic [DEPTH_WARP-1:0]           res_warpid_i,
  output logic                            wb_valid_o,
  input  logic                            wb_ready_i,
  output logic [EXPWIDTH+PRECISION:0]     wb_data_o,
  output logic [7:0]                      wb_reg_idxw_o,
  output logic [DEPTH_WARP-1:0]           wb_warpid_o,
  input  logic [DEPTH_WARP-1:0]           fflags_rd_warpid_i,
  output logic [4:0]                      fflags_rd_o,
  input  logic                            fflags_clr_i,
  input  logic [DEPTH_WARP-1:0]           fflags_clr_warpid_i,
  output logic [$clog2(FIFO_DEPTH):0]     count_o
);

  localparam int DW = EXPWIDTH + PRECISION + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = 2 ** DEPTH_WARP;
  localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

  logic [DW-1:0]         data_mem [FIFO_DEPTH];
  logic [7:0]            idx_mem  [FIFO_DEPTH];
  logic [DEPTH_WARP-1:0] warp_mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic [4:0]            flags [NW];
  logic                  empty, accept, pop, store;

  assign empty       = (count == '0);
  assign res_ready_o = (count != FULL);
  assign accept      = res_valid_i && res_ready_o;
  assign count_o     = count;
  assign pop         = !empty && wb_ready_i;

`ifdef FADD_WB_BYPASS_EN
  // An empty FIFO forwards the incoming result; it is only stored if the write port stalls.
  assign wb_valid_o    = !empty || res_valid_i;
  assign wb_data_o     = empty ? res_data_i     : data_mem[rd_ptr];
  assign wb_reg_idxw_o = empty ? res_reg_idxw_i : idx_mem[rd_ptr];
  assign wb_warpid_o   = empty ? res_warpid_i   : warp_mem[rd_ptr];
  assign store         = accept && !(empty && wb_ready_i);
`else
  assign wb_valid_o    = !empty;
  assign wb_data_o     = data_mem[rd_ptr];
  assign wb_reg_idxw_o = idx_mem[rd_ptr];
  assign wb_warpid_o   = warp_mem[rd_ptr];
  assign store         = accept;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({store, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      data_mem[wr_ptr] <= res_data_i;
      idx_mem[wr_ptr]  <= res_reg_idxw_i;
      warp_mem[wr_ptr] <= res_warpid_i;
    end
  end

  // Clear is applied before the OR so a same-warp clear+push leaves exactly the new flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned w = 0; w < NW; w++) flags[w] <= '0;
    end else begin
      for (int unsigned w = 0; w < NW; w++) begin
        flags[w] <= ((fflags_clr_i && fflags_clr_warpid_i == DEPTH_WARP'(w)) ? 5'b0 : flags[w])
                  | ((accept && res_warpid_i == DEPTH_WARP'(w)) ? res_fflags_i : 5'b0);
      end
    end
  end

  assign fflags_rd_o = flags[fflags_rd_warpid_i];

endmodule

// File: tb/tb_fadd_wb_collector.sv
// Self-checking bench for fadd_wb_collector: directed steps plus random traffic checked against
// a queue-based reference model of the collector and its per-warp sticky flags.
module tb_fadd_wb_collector;

  localparam int NW = 16;
  localparam int FD = 4;
`ifdef FADD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk, rst_n;
  logic       res_valid, res_ready, wb_valid, wb_ready, fflags_clr;
  logic [8:0] res_data, wb_data;
  logic [4:0] res_fflags, fflags_rd;
  logic [7:0] res_idx, wb_idx;
  logic [3:0] res_warp, wb_warp, rd_warp, clr_warp;
  logic [2:0] count;

  fadd_wb_collector #(
    .EXPWIDTH(5), .PRECISION(3), .DEPTH_WARP(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .res_valid_i(res_valid), .res_ready_o(res_ready), .res_data_i(res_data),
    .res_fflags_i(res_fflags), .res_reg_idxw_i(res_idx), .res_warpid_i(res_warp),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_data_o(wb_data),
    .wb_reg_idxw_o(wb_idx), .wb_warpid_o(wb_warp),
    .fflags_rd_warpid_i(rd_warp), .fflags_rd_o(fflags_rd),
    .fflags_clr_i(fflags_clr), .fflags_clr_warpid_i(clr_warp), .count_o(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [8:0] data;
    logic [7:0] idx;
    logic [3:0] warp;
  } ent_t;

  ent_t       q[$];
  logic [4:0] mflags [NW];
  int         passed = 0, failed = 0, total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [8:0] d, input logic [7:0] ix,
                       input logic [3:0] w, input logic [4:0] ff, input logic wr);
    res_valid  = v;
    res_data   = d;
    res_idx    = ix;
    res_warp   = w;
    res_fflags = ff;
    wb_ready   = wr;
  endtask

  // Called at posedge+1: checks outputs mid-cycle, then advances the model across the edge.
  task automatic cycle(output bit acc);
    bit   ev, pop, byp_taken;
    ent_t h, n;
    #4;
    ev = (q.size() != 0) || (BYP && res_valid);
    chk("res_ready", res_ready, q.size() != FD);
    chk("wb_valid", wb_valid, ev);
    chk("count", count, q.size());
    chk("fflags_rd", fflags_rd, mflags[rd_warp]);
    if (ev) begin
      if (q.size() != 0) h = q[0];
      else begin
        h.data = res_data; h.idx = res_idx; h.warp = res_warp;
      end
      chk("wb_data", wb_data, h.data);
      chk("wb_idx", wb_idx, h.idx);
      chk("wb_warp", wb_warp, h.warp);
    end
    acc = res_valid && (q.size() != FD);
    pop = ev && wb_ready;
    byp_taken = pop && (q.size() == 0);
    n.data = res_data; n.idx = res_idx; n.warp = res_warp;
    @(posedge clk);
    if (fflags_clr) mflags[clr_warp] = '0;
    if (acc) mflags[n.warp] = mflags[n.warp] | res_fflags;
    if (pop && !byp_taken) void'(q.pop_front());
    if (acc && !byp_taken) q.push_back(n);
    #1;
  endtask

  task automatic step();
    bit a;
    cycle(a);
  endtask

  task automatic drain();
    drive(1'b0, '0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 12 && q.size() != 0; i++) step();
    chk("drain_done", q.size(), 0);
  endtask

  initial begin
    bit acc;
    rst_n = 1'b0;
    fflags_clr = 1'b0; clr_warp = '0; rd_warp = '0;
    drive(1'b0, '0, '0, '0, '0, 1'b0);
    for (int w = 0; w < NW; w++) mflags[w] = '0;
    #2;
    chk("rst_count", count, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_res_ready", res_ready, 1);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single push of 1.0
    drive(1'b1, 9'h078, 8'h05, 4'd2, 5'b0, 1'b1);
    step();
    drive(1'b0, '0, '0, '0, '0, 1'b1);
`ifndef FADD_WB_BYPASS_EN
    chk("t1_valid", wb_valid, 1);
    chk("t1_data", wb_data, 9'h078);
    chk("t1_idx", wb_idx, 8'h05);
    chk("t1_warp", wb_warp, 4'd2);
`endif
    step();
    chk("t1_count_after", count, 0);
    chk("t1_valid_after", wb_valid, 0);

    // Fill to full with write port stalled, offer a 5th, then release
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 9'(i), 8'(8'h10 + i), 4'(i), 5'b0, 1'b0);
      step();
    end
    chk("t2_full_count", count, 4);
    chk("t2_full_ready", res_ready, 0);
    drive(1'b1, 9'h005, 8'h15, 4'd5, 5'b0, 1'b0);
    step();
    drive(1'b1, 9'h005, 8'h15, 4'd5, 5'b0, 1'b1);
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) cycle(acc);
    chk("t2_fifth_accepted", acc, 1);
    drain();

    // Steady-state push+pop at occupancy 2
    drive(1'b1, 9'h0A0, 8'h20, 4'd0, 5'b0, 1'b0); step();
    drive(1'b1, 9'h0A1, 8'h21, 4'd1, 5'b0, 1'b0); step();
    chk("t3_count_pre", count, 2);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 9'(9'h0A2 + i), 8'(8'h22 + i), 4'(i), 5'b0, 1'b1);
      step();
      chk("t3_count_hold", count, 2);
    end
    drain();

    // Sticky fflags accrual and clear
    fflags_clr = 1'b1; clr_warp = 4'd3; step();
    clr_warp = 4'd1; step();
    fflags_clr = 1'b0;
    drive(1'b1, 9'h011, 8'h30, 4'd3, 5'b00001, 1'b1); step();
    drive(1'b1, 9'h012, 8'h31, 4'd3, 5'b00100, 1'b1); step();
    drive(1'b1, 9'h013, 8'h32, 4'd1, 5'b10000, 1'b1); step();
    drive(1'b0, '0, '0, '0, '0, 1'b1);
    rd_warp = 4'd3; #1 chk("t4_flags_w3", fflags_rd, 5'b00101);
    rd_warp = 4'd1; #1 chk("t4_flags_w1", fflags_rd, 5'b10000);
    fflags_clr = 1'b1; clr_warp = 4'd3;
    drive(1'b1, 9'h014, 8'h33, 4'd3, 5'b00010, 1'b1);
    step();
    fflags_clr = 1'b0;
    drive(1'b0, '0, '0, '0, '0, 1'b1);
    rd_warp = 4'd3; #1 chk("t4_clr_push_w3", fflags_rd, 5'b00010);
    drain();

    // Asynchronous reset mid-operation with three entries buffered
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 9'(9'h150 + i), 8'(i), 4'(i + 7), 5'b01000, 1'b0);
      step();
    end
    chk("t5_count_pre", count, 3);
    drive(1'b0, '0, '0, '0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", wb_valid, 0);
    chk("t5_rst_count", count, 0);
    chk("t5_rst_ready", res_ready, 1);
    for (int w = 0; w < NW; w++) begin
      rd_warp = 4'(w);
      #0.1;
      chk("t5_rst_flags", fflags_rd, 0);
    end
    q.delete();
    for (int w = 0; w < NW; w++) mflags[w] = '0;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, '0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step();

`ifdef FADD_WB_BYPASS_EN
    // Same-cycle bypass through an empty FIFO
    drive(1'b1, 9'h0FF, 8'h44, 4'd6, 5'b00001, 1'b1);
    #1;
    chk("t6_byp_valid", wb_valid, 1);
    chk("t6_byp_data", wb_data, 9'h0FF);
    step();
    chk("t6_byp_count", count, 0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 9'($urandom), 8'($urandom), 4'($urandom),
            5'($urandom), 1'($urandom_range(0, 3) != 0));
      fflags_clr = ($urandom_range(0, 7) == 0);
      clr_warp   = 4'($urandom);
      rd_warp    = 4'($urandom);
      step();
    end
    fflags_clr = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
